// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and sequences fetch from a 1-cycle ROM.
// Handles start/halt, decode stalls and sign-magnitude branch redirects.
module fetch_sequencer #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               start,
    input  logic               halt_req,
    input  logic               stall,
    input  logic               branch,
    input  logic               taken,
    input  logic               jump_sign,
    input  logic [PC_W-1:0]    target,
    input  logic [PC_W-1:0]    branch_pc,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               flush,
    output logic               halted,
    output logic [15:0]        bubble_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fpc_q, fpc_d;
    logic            valid_q, valid_d;
    logic [15:0]     bcnt_q, bcnt_d;
    logic [PC_W-1:0] redir_pc;

    // Redirect target; wraps modulo 2^PC_W by construction.
    assign redir_pc = jump_sign ? (branch_pc + target) : (branch_pc - target);

    assign if_valid   = valid_q;
    assign if_instr   = rom_data;
    assign if_pc      = fpc_q;
    assign halted     = (state_q == HALT);
    assign bubble_cnt = bcnt_q;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fpc_q   <= RESET_PC;
            valid_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fpc_q   <= fpc_d;
            valid_q <= valid_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state, PC sequencing, ROM address and flush.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fpc_d    = fpc_q;
        valid_d  = valid_q;
        bcnt_d   = bcnt_q;
        rom_addr = pc_q;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((stall || !valid_q) && (bcnt_q != 16'hFFFF)) begin
                    bcnt_d = bcnt_q + 16'd1;
                end
                if (halt_req) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else if (branch && taken) begin
                    flush   = 1'b1;
                    pc_d    = redir_pc;
                    valid_d = 1'b0;
                end else if (stall) begin
                    // Re-read the held address so rom_data stays stable.
                    rom_addr = fpc_q;
                end else begin
                    fpc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a PC/instruction scoreboard.
// ROM is modelled as a synchronous read of a fixed address function.
module tb_fetch_sequencer;

    logic        clk;
    logic        init_n;
    logic        start;
    logic        halt_req;
    logic        stall;
    logic        branch;
    logic        taken;
    logic        jump_sign;
    logic [15:0] target;
    logic [15:0] branch_pc;
    logic [15:0] rom_addr;
    logic [8:0]  rom_data;
    logic        if_valid;
    logic [8:0]  if_instr;
    logic [15:0] if_pc;
    logic        flush;
    logic        halted;
    logic [15:0] bubble_cnt;

    int checks;
    int failures;
    logic [15:0] sb[$];

    fetch_sequencer dut (
        .clk        (clk),
        .init_n     (init_n),
        .start      (start),
        .halt_req   (halt_req),
        .stall      (stall),
        .branch     (branch),
        .taken      (taken),
        .jump_sign  (jump_sign),
        .target     (target),
        .branch_pc  (branch_pc),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .flush      (flush),
        .halted     (halted),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] rom_f(input logic [15:0] a);
        return (a[8:0] * 9'd37) ^ {a[15:9], 2'b10};
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop an expected PC whenever decode consumes an instruction.
    always @(negedge clk) begin
        if (init_n && if_valid && !stall && !flush && !halt_req
            && sb.size() > 0) begin
            logic [15:0] e;
            e = sb.pop_front();
            checks++;
            assert (if_pc === e && if_instr === rom_f(e)) else begin
                failures++;
                $error("FAIL sb_fetch observed=%0h/%0h expected=%0h/%0h",
                       if_pc, if_instr, e, rom_f(e));
            end
        end
    end

    task automatic do_branch(input logic [15:0] bp, input logic [15:0] t,
                             input logic s, input logic st,
                             input logic [15:0] exp, input logic [15:0] eb);
        sb.push_back(exp);
        sb.push_back(exp + 16'd1);
        branch = 1'b1;
        taken = 1'b1;
        jump_sign = s;
        branch_pc = bp;
        target = t;
        stall = st;
        #1;
        chk("br_flush", 32'(flush), 32'd1);
        tick();
        branch = 1'b0;
        taken = 1'b0;
        stall = 1'b0;
        #1;
        chk("br_flush_off", 32'(flush), 32'd0);
        chk("br_bubble_valid", 32'(if_valid), 32'd0);
        chk("br_rom_addr", 32'(rom_addr), 32'(exp));
        tick();
        chk("br_valid", 32'(if_valid), 32'd1);
        chk("br_if_pc", 32'(if_pc), 32'(exp));
        chk("br_instr", 32'(if_instr), 32'(rom_f(exp)));
        chk("br_bubble_cnt", 32'(bubble_cnt), 32'(eb));
        tick();
        tick();
        chk("br_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        init_n = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        stall = 1'b0;
        branch = 1'b0;
        taken = 1'b0;
        jump_sign = 1'b0;
        target = '0;
        branch_pc = '0;
        tick();
        tick();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_bubble", 32'(bubble_cnt), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);

        // Start and free-run fetch.
        init_n = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(16'(i));
        #1;
        chk("c0_valid", 32'(if_valid), 32'd0);
        tick();
        start = 1'b0;
        chk("c1_valid", 32'(if_valid), 32'd0);
        chk("c1_rom_addr", 32'(rom_addr), 32'd0);
        tick();
        chk("c2_valid", 32'(if_valid), 32'd1);
        chk("c2_if_pc", 32'(if_pc), 32'd0);
        tick();
        tick();
        tick();

        // Stall while if_pc=3 for three cycles.
        stall = 1'b1;
        #1;
        chk("stall_rom_addr", 32'(rom_addr), 32'd3);
        chk("stall_if_pc", 32'(if_pc), 32'd3);
        chk("stall_bub0", 32'(bubble_cnt), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_hold_pc", 32'(if_pc), 32'd3);
            chk("stall_hold_instr", 32'(if_instr), 32'(rom_f(16'd3)));
            chk("stall_hold_addr", 32'(rom_addr), 32'd3);
        end
        tick();
        stall = 1'b0;
        sb.push_back(16'd4);
        sb.push_back(16'd5);
        chk("stall_end_pc", 32'(if_pc), 32'd3);
        chk("stall_end_instr", 32'(if_instr), 32'(rom_f(16'd3)));
        chk("stall_bub", 32'(bubble_cnt), 32'd4);
        tick();
        chk("resume_pc", 32'(if_pc), 32'd4);
        tick();
        tick();
        chk("run_sb_empty", 32'(sb.size()), 32'd0);

        // Redirects, including wrap in both directions.
        do_branch(16'h0010, 16'd5, 1'b1, 1'b1, 16'h0015, 16'd6);
        do_branch(16'h0010, 16'd5, 1'b0, 1'b0, 16'h000B, 16'd7);
        do_branch(16'hFFFE, 16'd1, 1'b1, 1'b0, 16'hFFFF, 16'd8);
        do_branch(16'h0002, 16'd5, 1'b0, 1'b0, 16'hFFFD, 16'd9);

        // Not-taken branch does not flush.
        branch = 1'b1;
        taken = 1'b0;
        #1;
        chk("nt_flush", 32'(flush), 32'd0);
        tick();
        branch = 1'b0;

        // Halt beats a taken branch.
        halt_req = 1'b1;
        branch = 1'b1;
        taken = 1'b1;
        branch_pc = 16'h0040;
        target = 16'd1;
        jump_sign = 1'b1;
        #1;
        chk("halt_flush", 32'(flush), 32'd0);
        tick();
        halt_req = 1'b0;
        branch = 1'b0;
        taken = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(if_valid), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("halt_start_ign", 32'(halted), 32'd1);
        chk("halt_valid2", 32'(if_valid), 32'd0);
        chk("halt_bubble", 32'(bubble_cnt), 32'd9);
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_bubble", 32'(bubble_cnt), 32'd0);
        chk("unhalt_valid", 32'(if_valid), 32'd0);
        chk("unhalt_rom_addr", 32'(rom_addr), 32'd0);

        // Reset during a stall.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        stall = 1'b1;
        tick();
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        #1;
        chk("rs_valid", 32'(if_valid), 32'd0);
        chk("rs_if_pc", 32'(if_pc), 32'd0);
        chk("rs_rom_addr", 32'(rom_addr), 32'd0);
        chk("rs_bubble", 32'(bubble_cnt), 32'd0);
        chk("rs_flush", 32'(flush), 32'd0);
        tick();
        stall = 1'b0;
        chk("rs_idle_valid", 32'(if_valid), 32'd0);

        // Reset one cycle after a redirect.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        branch = 1'b1;
        taken = 1'b1;
        branch_pc = 16'h0020;
        target = 16'd3;
        jump_sign = 1'b1;
        tick();
        branch = 1'b0;
        taken = 1'b0;
        init_n = 1'b0;
        tick();
        init_n = 1'b1;
        #1;
        chk("rb_valid", 32'(if_valid), 32'd0);
        chk("rb_if_pc", 32'(if_pc), 32'd0);
        chk("rb_rom_addr", 32'(rom_addr), 32'd0);
        chk("rb_bubble", 32'(bubble_cnt), 32'd0);
        chk("rb_flush", 32'(flush), 32'd0);
        tick();
        chk("rb_no_stale", 32'(if_valid), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch from the synchronous instruction ROM (1-cycle read latency, 9-bit instructions). Handles start/halt, decode-stage stalls and taken-branch redirects with sign-magnitude offsets. Supplies decode with a valid-qualified instruction/PC pair and a flush pulse. Sits between the instruction ROM and the decode stage, replacing ad-hoc combinational next-PC logic with a registered controller.

Parameters:
PC_W, 16, program counter / ROM address width
INSTR_W, 9, instruction width
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
init_n  in  1  synchronous active-low reset
start  in  1  leave IDLE and begin fetching
halt_req  in  1  stop fetching, enter HALT
stall  in  1  decode cannot accept; hold current fetch output
branch  in  1  resolved branch present this cycle
taken  in  1  branch taken (qualified by branch)
jump_sign  in  1  1: add offset, 0: subtract offset
target  in  PC_W  branch offset magnitude
branch_pc  in  PC_W  PC of the resolving branch instruction
rom_addr  out  PC_W  ROM read address (combinational from state)
rom_data  in  INSTR_W  ROM read data, valid 1 cycle after rom_addr
if_valid  out  1  if_instr/if_pc hold a live instruction
if_instr  out  INSTR_W  fetched instruction (= rom_data)
if_pc  out  PC_W  address of if_instr
flush  out  1  kill younger instructions in decode (combinational)
halted  out  1  state == HALT
bubble_cnt  out  16  saturating count of RUN cycles with if_valid=0 or stall=1

Behaviour:
- Clock port clk; reset port init_n, synchronous, active-low. Sampled low at any edge: state=IDLE, pc=RESET_PC, fpc_q=RESET_PC, valid_q=0, bubble_cnt=0. Overrides all other inputs, including mid-redirect or mid-stall.
- Registers: pc (address issued this cycle), fpc_q (address issued last cycle), valid_q. if_pc=fpc_q, if_valid=valid_q, if_instr=rom_data.
- States: IDLE, RUN, HALT.
- IDLE: rom_addr=pc, valid_q<=0, flush=0. start=1 -> RUN. Other inputs ignored.
- RUN, in priority order:
  1. halt_req=1: -> HALT, valid_q<=0, pc held, flush=0.
  2. branch&taken: flush=1 this cycle. new = jump_sign ? branch_pc+target : branch_pc-target, mod 2^PC_W. pc<=new, valid_q<=0. Stall ignored this cycle.
  3. stall=1: rom_addr=fpc_q (re-read held instruction so rom_data stays consistent). pc, fpc_q and valid_q held.
  4. Normal (includes branch with taken=0): rom_addr=pc, fpc_q<=pc, valid_q<=1, pc<=pc+1.
- Redirect timing: branch accepted cycle T. Cycle T+1: rom_addr=new, if_valid=0. Cycle T+2: if_valid=1, if_pc=new.
- First fetch after start: start sampled at T. RUN at T+1 issues RESET_PC. if_valid=1 with if_pc=RESET_PC at T+2.
- HALT: valid_q=0, halted=1, rom_addr=pc, flush=0. Exit only via init_n=0; start is ignored.
- PC wrap: 0xFFFF+1 -> 0x0000. Redirect arithmetic wraps silently; no error flag.
- flush is only ever 1 in RUN with branch&taken and halt_req=0.
- bubble_cnt: increments each RUN cycle where valid_q=0 or stall=1. Saturates at 0xFFFF. Not counted in IDLE/HALT.
- start in RUN/HALT, and branch/stall in IDLE/HALT: no effect.

Test Plan:
- Reset then start at cycle 0, no stalls -> if_valid rises cycle 2; if_pc = 0,1,2,3 on cycles 2..5; if_instr equals ROM contents at those addresses.
- Stall at if_pc=3 held 3 cycles -> if_pc=3 and if_instr constant for 4 cycles, rom_addr=3 during stall, bubble_cnt+3; resumes with 4.
- Branch at branch_pc=0x0010, target=5, jump_sign=1, with stall=1 -> flush=1 one cycle, stall ignored, if_valid=0 one cycle, then if_pc=0x0015; repeat with jump_sign=0 -> 0x000B.
- Wrap cases: pc=0xFFFF -> next if_pc 0x0000. Branch branch_pc=0x0002, target=5, jump_sign=0 -> if_pc 0xFFFD.
- halt_req asserted together with branch&taken -> HALT, flush=0, halted=1, if_valid=0. start ignored. init_n=0 -> IDLE, pc=0, bubble_cnt=0.
- init_n low for one cycle during stall and again one cycle after a redirect -> IDLE next cycle, all outputs at reset values, no stale if_valid.
